// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and opcode-class helpers for the multi-cycle ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t ALU_ADD   = 4'd0;
  localparam op_t ALU_SUB   = 4'd1;
  localparam op_t ALU_AND   = 4'd2;
  localparam op_t ALU_OR    = 4'd3;
  localparam op_t ALU_XOR   = 4'd4;
  localparam op_t ALU_SLT   = 4'd5;
  localparam op_t ALU_SLTU  = 4'd6;
  localparam op_t ALU_SLL   = 4'd7;
  localparam op_t ALU_SRL   = 4'd8;
  localparam op_t ALU_SRA   = 4'd9;
  localparam op_t ALU_MUL   = 4'd10;
  localparam op_t ALU_MULHU = 4'd11;
  localparam op_t ALU_DIVU  = 4'd12;
  localparam op_t ALU_REMU  = 4'd13;
  localparam op_t ALU_DIV   = 4'd14;
  localparam op_t ALU_REM   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ops that go through the iterative multiply/divide unit.
  function automatic logic is_muldiv(input op_t op);
    return op >= ALU_MUL;
  endfunction

  // Divide and remainder ops (signed or unsigned).
  function automatic logic is_div(input op_t op);
    return op >= ALU_DIVU;
  endfunction

  // Signed divide and remainder ops.
  function automatic logic is_signed_div(input op_t op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bus between the execute stage and the multi-cycle ALU.
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int unsigned P = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [P-1:0] A;
  logic [P-1:0] B;
  op_t          ALUControl;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] Result;
  logic         V;
  logic         C;
  logic         N;
  logic         Z;

  modport master (
    output in_valid, A, B, ALUControl, out_ready,
    input  in_ready, out_valid, Result, V, C, N, Z
  );

  modport slave (
    input  in_valid, A, B, ALUControl, out_ready,
    output in_ready, out_valid, Result, V, C, N, Z
  );

endinterface

// File: rtl/alu_mc_muldiv.sv
// Shared radix-2 shift-add multiplier / restoring divider, one step per cycle.
// The final step's result (with sign fixup) is presented combinationally on
// result_c during the cycle done_c is high, so the caller can register it.
module alu_mc_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned P = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  op_t          op,
  input  logic [P-1:0] a,
  input  logic [P-1:0] b,
  output logic         done_c,
  output logic [P-1:0] result_c
);

  localparam int unsigned CW = $clog2(P);
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  logic           busy;
  logic [CW-1:0]  cnt;
  op_t            op_q;
  logic [2*P-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [P-1:0]   opnd;       // multiplicand or divisor magnitude
  logic           neg_q;
  logic           neg_r;

  logic           a_neg;
  logic           b_neg;
  logic [P-1:0]   a_mag;
  logic [P-1:0]   b_mag;
  logic           mul_start;
  logic           mul_q;
  logic [P:0]     add_sum;
  logic [P:0]     shifted;
  logic [P:0]     sub_diff;
  logic [2*P-1:0] acc_next;

  // Operand magnitudes and sign bookkeeping for a new request.
  always_comb begin
    a_neg     = is_signed_div(op) & a[P-1];
    b_neg     = is_signed_div(op) & b[P-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    mul_start = (op == ALU_MUL) || (op == ALU_MULHU);
  end

  // One multiply or divide step on the working register.
  always_comb begin
    mul_q    = (op_q == ALU_MUL) || (op_q == ALU_MULHU);
    add_sum  = {1'b0, acc[2*P-1:P]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = {acc[2*P-1:P], acc[P-1]};
    sub_diff = shifted - {1'b0, opnd};
    if (mul_q) begin
      acc_next = {add_sum, acc[P-1:1]};
    end else if (!sub_diff[P]) begin
      acc_next = {sub_diff[P-1:0], acc[P-2:0], 1'b1};
    end else begin
      acc_next = {shifted[P-1:0], acc[P-2:0], 1'b0};
    end
  end

  // Result selection and sign fixup on the last step.
  always_comb begin
    done_c = busy && (cnt == LAST);
    case (op_q)
      ALU_MUL:            result_c = acc_next[P-1:0];
      ALU_MULHU:          result_c = acc_next[2*P-1:P];
      ALU_DIVU, ALU_DIV:  result_c = neg_q ? -acc_next[P-1:0] : acc_next[P-1:0];
      default:            result_c = neg_r ? -acc_next[2*P-1:P] : acc_next[2*P-1:P];
    endcase
  end

  // Load on start, then iterate P steps with the counter running 0..P-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      cnt   <= '0;
      op_q  <= ALU_ADD;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      op_q  <= op;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (mul_start) begin
        acc  <= {{P{1'b0}}, b};
        opnd <= a;
      end else begin
        acc  <= {{P{1'b0}}, a_mag};
        opnd <= b_mag;
      end
    end else if (busy) begin
      acc <= acc_next;
      if (cnt == LAST) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: control FSM, single-cycle datapath, flags
// and output registers; multiply/divide is delegated to alu_mc_muldiv.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned P = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);

  localparam int unsigned SW = $clog2(P);
  localparam logic [P-1:0] MIN_NEG = {1'b1, {(P-1){1'b0}}};

  state_t       state;

  logic [SW-1:0] shamt;
  logic [P:0]    add_sum;
  logic [P:0]    sub_sum;
  logic          lt_s;
  logic          lt_u;
  logic          special_c;
  logic [P-1:0]  simple_res_c;
  logic          simple_v_c;
  logic          simple_c_c;
  logic          md_start_c;
  logic          md_done_c;
  logic [P-1:0]  md_result_c;
  logic [P-1:0]  load_res_c;

  // Single-cycle ops and the directly resolved divide corner cases.
  always_comb begin
    shamt        = bus.B[SW-1:0];
    add_sum      = {1'b0, bus.A} + {1'b0, bus.B};
    sub_sum      = {1'b0, bus.A} + {1'b0, ~bus.B} + (P+1)'(1);
    lt_s         = $signed(bus.A) < $signed(bus.B);
    lt_u         = bus.A < bus.B;
    special_c    = is_div(bus.ALUControl) &&
                   ((bus.B == '0) ||
                    (is_signed_div(bus.ALUControl) && (bus.A == MIN_NEG) && (bus.B == '1)));
    simple_res_c = '0;
    simple_v_c   = 1'b0;
    simple_c_c   = 1'b0;
    case (bus.ALUControl)
      ALU_ADD: begin
        simple_res_c = add_sum[P-1:0];
        simple_c_c   = add_sum[P];
        simple_v_c   = (bus.A[P-1] == bus.B[P-1]) && (add_sum[P-1] != bus.A[P-1]);
      end
      ALU_SUB: begin
        simple_res_c = sub_sum[P-1:0];
        simple_c_c   = sub_sum[P];
        simple_v_c   = (bus.A[P-1] != bus.B[P-1]) && (sub_sum[P-1] != bus.A[P-1]);
      end
      ALU_AND:  simple_res_c = bus.A & bus.B;
      ALU_OR:   simple_res_c = bus.A | bus.B;
      ALU_XOR:  simple_res_c = bus.A ^ bus.B;
      ALU_SLT:  simple_res_c = {{(P-1){1'b0}}, lt_s};
      ALU_SLTU: simple_res_c = {{(P-1){1'b0}}, lt_u};
      ALU_SLL:  simple_res_c = bus.A << shamt;
      ALU_SRL:  simple_res_c = bus.A >> shamt;
      ALU_SRA:  simple_res_c = $signed(bus.A) >>> shamt;
      // Only used when special_c: divide by zero or signed overflow.
      ALU_DIVU, ALU_DIV: simple_res_c = (bus.B == '0) ? '1 : bus.A;
      ALU_REMU, ALU_REM: simple_res_c = (bus.B == '0) ? bus.A : '0;
      default: ;
    endcase
  end

  // Launch the iterative unit only for genuine multiply/divide work.
  always_comb begin
    md_start_c = (state == IDLE) && bus.in_valid && is_muldiv(bus.ALUControl) && !special_c;
    load_res_c = (state == CALC) ? md_result_c : simple_res_c;
  end

  alu_mc_muldiv #(
    .P (P)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start_c),
    .op       (bus.ALUControl),
    .a        (bus.A),
    .b        (bus.B),
    .done_c   (md_done_c),
    .result_c (md_result_c)
  );

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.Result    <= '0;
      bus.V         <= 1'b0;
      bus.C         <= 1'b0;
      bus.N         <= 1'b0;
      bus.Z         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            if (md_start_c) begin
              state <= CALC;
            end else begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.Result    <= load_res_c;
              bus.V         <= simple_v_c;
              bus.C         <= simple_c_c;
              bus.N         <= load_res_c[P-1];
              bus.Z         <= (load_res_c == '0);
            end
          end
        end
        CALC: begin
          if (md_done_c) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.Result    <= load_res_c;
            bus.V         <= 1'b0;
            bus.C         <= 1'b0;
            bus.N         <= load_res_c[P-1];
            bus.Z         <= (load_res_c == '0);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISC-V datapath: extends the single-cycle ADD/SUB/AND/OR/SLT ALU with XOR, SLTU, shifts, and iterative multiply/divide/remainder (RV32M subset). It sits in the execute stage behind a valid/ready handshake, with registered results and V/C/N/Z flags. Simple ops complete in one cycle; MUL/DIV ops take P+1 cycles. It is the first ALU in the design that can stall the pipeline.

## Interface
- P, 32, operand/result width; must be a power of two, ≥ 8.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  P  operand A (dividend / multiplicand).
- B  in  P  operand B (divisor / multiplier / shift amount).
- ALUControl  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11 MULHU, 12 DIVU, 13 REMU, 14 DIV, 15 REM.
- out_valid  out  1  Result and flags valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- Result  out  P  registered result.
- V, C, N, Z  out  1 each  registered flags.

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE.
- IDLE: in_ready=1. Handshake on in_valid & in_ready captures A, B, and ALUControl; later input changes are ignored.
  - Ops 0–9 and special-case divides → DONE.
  - Ops 10–15 otherwise → CALC.
- CALC: one radix-2 step per cycle, iteration counter 0..P-1. At count P-1, apply sign fixup and load Result → DONE.
  - MUL: low P bits of the product.
  - MULHU: high P bits of the unsigned 2P-bit product.
  - DIV/REM: operate on magnitudes. Negate the quotient if the operand signs differ. The remainder takes the sign of the dividend.
- DONE: out_valid=1, outputs stable. On out_ready → IDLE.
- Arithmetic rules:
  - ADD/SUB are P-bit wrap-around. SUB computes A + ~B + 1.
  - SLT/SLTU return {0…, 1} when A < B (signed / unsigned compare), else 0.
  - Shifts use B[log2(P)-1:0] only. SRA sign-extends.
- Divide special cases (resolved directly, no CALC):
  - B=0: quotient all-ones, remainder = A.
  - DIV/REM with A = −2^(P−1) and B = −1: quotient = A, remainder = 0.
- Flags are computed from the final Result and loaded together with it:
  - N = Result[P-1].
  - Z = (Result == 0).
  - V, ADD: A and B have the same sign and the sum sign differs.
  - V, SUB: A and B have different signs and the result sign differs from A.
  - C, ADD: carry-out. C, SUB: carry-out of A + ~B + 1 (1 iff A ≥ B unsigned).
  - V = C = 0 for all other ops.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, Result=0, V=C=N=Z=0, counter=0.
- Reset during CALC or DONE aborts the op; no out_valid is produced.
- Latency from the accept edge to out_valid high:
  - 1 cycle for ops 0–9 and special-case divides.
  - P+1 cycles for MUL/DIV ops (P in CALC plus the DONE entry).
- Throughput: at most one op per 2 cycles. The accept and out_ready cycles never overlap because in_ready=0 outside IDLE.
- out_valid held with out_ready=0: Result and flags must not change.
- in_valid while busy: ignored, not queued.
- out_ready without out_valid: no effect.

## Structure
- Package alu_pkg:
  - 4-bit opcode localparams (ALU_ADD … ALU_REM).
  - FSM state enum.
  - Helper function is_muldiv(op).
- Sub-module alu_mc_muldiv: shared shift-add multiplier / restoring divider with a start/done interface, counter, and sign fixup. The top level holds the FSM, the simple-op datapath, the flag logic, and the output registers.

## Test plan
- P=32, ADD 0x7FFFFFFF + 1 → Result 0x80000000, V=1, C=0, N=1, Z=0; out_valid 1 cycle after accept.
- SUB 5 − 5 → Result 0, Z=1, C=1, V=0. SLT −1 < 1 → 1. SLTU 0xFFFFFFFF < 1 → 0.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIV −7 / 2 → −3; REM −7 / 2 → −1; DIVU 7 / 0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000 / −1 → 0x80000000.
- Hold out_ready=0 for 10 cycles in DONE → outputs stable; toggle in_valid meanwhile → not accepted.
- Assert reset at CALC cycle 10 → next cycle IDLE, out_valid=0, all outputs 0; a following ADD completes normally.
